uart_byte_rx: RTL and testbench

Serial-to-byte UART receiver (8N1, LSB first) that sits directly upstream of the frame parser on the host link. It synchronises the raw RX pin and samples each bit at its midpoint. Each good byte is presented as a one-cycle `byte_valid` pulse with `byte_data`, which the parser consumes as `frame_data_ena`/`frame_data_in`. It also flags framing errors and a line-idle timeout, which the parser uses to resynchronise on a frame head.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_byte_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART state encoding and default timing constants.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int c_CLKS_PER_BIT_DFLT = 868;
    localparam int c_IDLE_BITS_DFLT    = 20;

    localparam int c_DATA_BITS = 8;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
//  Module   : uart_rx_sync
//  Brief    : Two-flop synchroniser with a parameterised reset value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
//  Module   : uart_byte_rx
//  Brief    : 8N1 UART receiver, mid-bit sampling, framing-error and idle flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DFLT,
    parameter int IDLE_BITS    = c_IDLE_BITS_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       rx_idle
);

    localparam int CW            = $clog2(CLKS_PER_BIT);
    localparam int c_IDLE_TERM   = IDLE_BITS * CLKS_PER_BIT;
    localparam int ITW           = $clog2(c_IDLE_TERM);

    localparam logic [CW-1:0]  c_HALF_M1   = CW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CW-1:0]  c_BIT_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);
    localparam logic [2:0]     c_IDX_LAST  = 3'(c_DATA_BITS - 1);
    localparam logic [ITW-1:0] c_IDLE_LAST = ITW'(c_IDLE_TERM - 1);
    localparam logic [ITW-1:0] c_IDLE_ONE  = ITW'(1);

    logic            w_rx_s;

    uart_state_t     r_state;
    uart_state_t     w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic [7:0]      r_data;
    logic [7:0]      w_data_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_ferr;
    logic            w_ferr_nxt;
    logic            w_cnt_zero;

    logic [ITW-1:0]  r_idle_cnt;
    logic            r_idle_armed;
    logic            r_rx_idle;

    uart_rx_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = c_HALF_M1;
                end
            end

            ST_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (!w_rx_s) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = c_BIT_M1;
                    w_idx_nxt   = '0;
                end else begin
                    // Line went back high before mid-start: treat as a glitch.
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_cnt_nxt          = c_BIT_M1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (w_rx_s) begin
                    w_data_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = ST_BREAK;
                end
            end

            ST_BREAK: begin
                // A held-low line stays here silently until it is released.
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Idle timer: armed by a good byte, fires once after a quiet line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle_cnt   <= '0;
            r_idle_armed <= 1'b0;
            r_rx_idle    <= 1'b0;
        end else begin
            r_rx_idle <= 1'b0;
            if (w_valid_nxt) begin
                r_idle_armed <= 1'b1;
            end
            if ((r_state == ST_IDLE) && w_rx_s && r_idle_armed) begin
                if (r_idle_cnt == c_IDLE_LAST) begin
                    r_rx_idle    <= 1'b1;
                    r_idle_armed <= 1'b0;
                    r_idle_cnt   <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign byte_data  = r_data;
    assign byte_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != ST_IDLE);
    assign rx_idle    = r_rx_idle;

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// ============================================================================
//  Module   : tb_uart_byte_rx
//  Brief    : Directed self-checking bench for uart_byte_rx (16 clks/bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_byte_rx;

    localparam int c_CPB  = 16;
    localparam int c_IDLE = 4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;
    logic       rx_idle;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_idle = 0, n_both = 0;
    int last_valid_cyc = -1, last_ferr_cyc = -1, last_idle_cyc = -1;
    int busy_rise_cyc = -1, busy_fall_cyc = -1;
    logic [7:0] last_data = 8'h00;
    logic busy_q = 1'b0;
    int t0_exp = 0;

    uart_byte_rx #(
        .CLKS_PER_BIT (c_CPB),
        .IDLE_BITS    (c_IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .rx_idle    (rx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Times recorded here are the index of the clk edge that produced the level.
    always @(negedge clk) begin
        if (byte_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            last_data      = byte_data;
        end
        if (frame_err) begin
            n_ferr++;
            last_ferr_cyc = cyc;
        end
        if (rx_idle) begin
            n_idle++;
            last_idle_cyc = cyc;
        end
        if (byte_valid && frame_err) n_both++;
        if (busy && !busy_q) busy_rise_cyc = cyc;
        if (!busy && busy_q) busy_fall_cyc = cyc;
        busy_q = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a clk edge e0; the FSM sees the start at e0+3.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        t0_exp = cyc + 3;
        rx = 1'b0;
        wait_cycles(c_CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(c_CPB);
        end
        rx = stop_bit;
        wait_cycles(c_CPB);
    endtask

    initial begin
        int t0_a;
        int v_first;
        int nv, nf, ni;

        rst_n = 1'b0;
        rx    = 1'b1;
        @(posedge clk); #1;
        wait_cycles(3);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_idle", rx_idle, 1'b0);
        rst_n = 1'b1;
        wait_cycles(10);

        // Single byte 0xEB: valid registered at t0+152 (captured downstream at t0+153)
        send_byte(8'hEB, 1'b1);
        t0_a = t0_exp;
        wait_cycles(4);
        check("eb_count", n_valid, 1);
        check("eb_data", last_data, 8'hEB);
        check("eb_valid_time", last_valid_cyc, t0_a + 152);
        check("eb_busy_rise", busy_rise_cyc, t0_a);
        check("eb_busy_fall", busy_fall_cyc, t0_a + 152);
        check("eb_no_ferr", n_ferr, 0);

        // Idle timeout: one pulse 64 cycles after returning to IDLE, then silence
        wait_cycles(100);
        check("idle_count", n_idle, 1);
        check("idle_time", last_idle_cyc, last_valid_cyc + c_IDLE * c_CPB);
        wait_cycles(500);
        check("idle_no_repeat", n_idle, 1);

        // Back-to-back 0xEB, 0x9C with one stop bit
        nv = n_valid;
        send_byte(8'hEB, 1'b1);
        v_first = last_valid_cyc;
        check("b2b_first_data", last_data, 8'hEB);
        send_byte(8'h9C, 1'b1);
        wait_cycles(4);
        check("b2b_count", n_valid, nv + 2);
        check("b2b_second_data", last_data, 8'h9C);
        check("b2b_spacing", last_valid_cyc - v_first, 160);
        wait_cycles(100);

        // Start glitch: 4 low cycles, rejected at mid-start
        nv = n_valid;
        nf = n_ferr;
        t0_exp = cyc + 3;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(40);
        check("glitch_no_valid", n_valid, nv);
        check("glitch_no_ferr", n_ferr, nf);
        check("glitch_busy_fall", busy_fall_cyc, t0_exp + 8);

        // Framing error, then a break held low for 200 cycles
        nv = n_valid;
        nf = n_ferr;
        send_byte(8'h55, 1'b0);
        t0_a = t0_exp;
        wait_cycles(200);
        check("ferr_count", n_ferr, nf + 1);
        check("ferr_time", last_ferr_cyc, t0_a + 152);
        check("ferr_no_valid", n_valid, nv);
        check("ferr_data_held", byte_data, 8'h9C);
        check("break_busy", busy, 1'b1);
        rx = 1'b1;
        wait_cycles(20);
        check("break_released", busy, 1'b0);
        check("break_single_ferr", n_ferr, nf + 1);
        send_byte(8'h01, 1'b1);
        wait_cycles(4);
        check("after_break_count", n_valid, nv + 1);
        check("after_break_data", last_data, 8'h01);
        wait_cycles(100);

        // Reset asserted in the middle of data bit 4
        nv = n_valid;
        nf = n_ferr;
        rx = 1'b0;
        wait_cycles(c_CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_cycles(c_CPB);
        end
        rx = 1'b1;
        wait_cycles(c_CPB / 2);
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        wait_cycles(2);
        check("abort_rst_data", byte_data, 8'h00);
        check("abort_rst_valid", byte_valid, 1'b0);
        check("abort_rst_ferr", frame_err, 1'b0);
        check("abort_rst_busy", busy, 1'b0);
        check("abort_rst_idle", rx_idle, 1'b0);
        rst_n = 1'b1;
        ni = n_idle;
        wait_cycles(200);
        check("abort_no_valid", n_valid, nv);
        check("abort_no_ferr", n_ferr, nf);
        check("abort_idle_unarmed", n_idle, ni);
        send_byte(8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_count", n_valid, nv + 1);
        check("a5_data", last_data, 8'hA5);
        check("a5_port_data", byte_data, 8'hA5);

        check("never_both", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
